// File: rtl/datapath_regs.sv
// Execution datapath: three working registers, operand muxes, 4-function ALU,
// write-back with per-register clear, registered output port and carry flag.
module datapath_regs #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resDatapath,
  input  logic [1:0]       wen,
  input  logic             wsel,
  input  logic [1:0]       asel,
  input  logic [1:0]       bsel,
  input  logic             datasel,
  input  logic [1:0]       alusel,
  input  logic [2:0]       resReg,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut,
  output logic             eq,
  output logic             carry
);

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r0_r, r1_r, r2_r;
  logic [WIDTH-1:0] dout_r;
  logic             carry_r;

  logic [WIDTH-1:0] a_bus_s, b_bus_s;
  logic [WIDTH:0]   sum_s, dif_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_flag_s;
  logic [WIDTH-1:0] wd_s;
  logic             tgt_clr_s;

  // Operand muxes: A and B bus selection from registers or constants
  always_comb begin
    a_bus_s = ZERO_C;
    b_bus_s = ONE_C;
    case (asel)
      2'b00:   a_bus_s = r0_r;
      2'b01:   a_bus_s = r1_r;
      2'b10:   a_bus_s = r2_r;
      default: a_bus_s = ZERO_C;
    endcase
    case (bsel)
      2'b00:   b_bus_s = r0_r;
      2'b01:   b_bus_s = r1_r;
      2'b10:   b_bus_s = r2_r;
      default: b_bus_s = ONE_C;
    endcase
  end

  assign sum_s = {1'b0, a_bus_s} + {1'b0, b_bus_s};
  assign dif_s = {1'b0, a_bus_s} + {1'b0, ~b_bus_s} + {{WIDTH{1'b0}}, 1'b1};

  // ALU: subtraction reports borrow, the inverted carry-out of A + ~B + 1
  always_comb begin
    alu_res_s  = ZERO_C;
    alu_flag_s = 1'b0;
    case (alusel)
      2'b00: begin
        alu_res_s  = sum_s[WIDTH-1:0];
        alu_flag_s = sum_s[WIDTH];
      end
      2'b01: begin
        alu_res_s  = dif_s[WIDTH-1:0];
        alu_flag_s = ~dif_s[WIDTH];
      end
      2'b10: begin
        alu_res_s  = a_bus_s & b_bus_s;
        alu_flag_s = 1'b0;
      end
      default: begin
        alu_res_s  = a_bus_s | b_bus_s;
        alu_flag_s = 1'b0;
      end
    endcase
  end

  // Write-back data and whether the write target is being cleared this edge
  always_comb begin
    wd_s      = ZERO_C;
    tgt_clr_s = 1'b0;
    if (datasel) begin
      wd_s = dataIn;
    end else begin
      wd_s = alu_res_s;
    end
    case (wen)
      2'b01:   tgt_clr_s = resReg[0];
      2'b10:   tgt_clr_s = resReg[1];
      2'b11:   tgt_clr_s = resReg[2];
      default: tgt_clr_s = 1'b0;
    endcase
  end

  // Working registers; a clear bit overrides a write to the same register
  always_ff @(posedge clk or posedge resDatapath) begin
    if (resDatapath) begin
      r0_r <= ZERO_C;
      r1_r <= ZERO_C;
      r2_r <= ZERO_C;
    end else begin
      if (resReg[0])          r0_r <= ZERO_C;
      else if (wen == 2'b01)  r0_r <= wd_s;
      if (resReg[1])          r1_r <= ZERO_C;
      else if (wen == 2'b10)  r1_r <= wd_s;
      if (resReg[2])          r2_r <= ZERO_C;
      else if (wen == 2'b11)  r2_r <= wd_s;
    end
  end

  // Output port captures the pre-write A bus; carry follows ALU write-backs only
  always_ff @(posedge clk or posedge resDatapath) begin
    if (resDatapath) begin
      dout_r  <= ZERO_C;
      carry_r <= 1'b0;
    end else begin
      if (wsel) dout_r <= a_bus_s;
      if ((wen != 2'b00) && !datasel && !tgt_clr_s) carry_r <= alu_flag_s;
    end
  end

  assign dataOut = dout_r;
  assign carry   = carry_r;
  assign eq      = (a_bus_s == b_bus_s);

endmodule

// File: tb/tb_datapath_regs.sv
// Directed bench for datapath_regs: an arithmetic reference model checked every
// cycle, plus hand-computed expectations from the test plan.
module tb_datapath_regs;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   wen = 2'b00;
  logic         wsel = 1'b0;
  logic [1:0]   asel = 2'b00;
  logic [1:0]   bsel = 2'b00;
  logic         datasel = 1'b0;
  logic [1:0]   alusel = 2'b00;
  logic [2:0]   resreg = 3'b000;
  logic [W-1:0] din = 8'h00;
  logic [W-1:0] dataOut;
  logic         eq;
  logic         carry;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] m_r [3];
  logic [W-1:0] m_dout;
  logic         m_carry;

  datapath_regs #(.WIDTH(W)) dut (
    .clk(clk), .resDatapath(rst), .wen(wen), .wsel(wsel), .asel(asel),
    .bsel(bsel), .datasel(datasel), .alusel(alusel), .resReg(resreg),
    .dataIn(din), .dataOut(dataOut), .eq(eq), .carry(carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] opnd(input logic [1:0] sel, input logic is_b);
    if (sel == 2'd3) return is_b ? W'(1) : W'(0);
    return m_r[int'(sel)];
  endfunction

  // {flag, result} from plain integer arithmetic
  function automatic logic [W:0] alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [1:0] op);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint m = longint'(1) << W;
    logic [W:0] r;
    case (op)
      2'd0: begin r[W-1:0] = W'((ua + ub) % m); r[W] = ((ua + ub) >= m); end
      2'd1: begin r[W-1:0] = W'((ua - ub + m) % m); r[W] = (ua < ub); end
      2'd2: begin r[W-1:0] = a & b; r[W] = 1'b0; end
      default: begin r[W-1:0] = a | b; r[W] = 1'b0; end
    endcase
    return r;
  endfunction

  function automatic logic [W-1:0] model_wd();
    logic [W:0] r;
    r = alu(opnd(asel, 1'b0), opnd(bsel, 1'b1), alusel);
    return datasel ? din : r[W-1:0];
  endfunction

  function automatic logic model_flag();
    logic [W:0] r;
    r = alu(opnd(asel, 1'b0), opnd(bsel, 1'b1), alusel);
    return r[W];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) m_r[i] <= '0;
      m_dout  <= '0;
      m_carry <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (resreg[i]) m_r[i] <= '0;
        else if (int'(wen) == i + 1) m_r[i] <= model_wd();
      end
      if (wen != 2'b00 && !datasel && !resreg[int'(wen) - 1]) m_carry <= model_flag();
      if (wsel) m_dout <= opnd(asel, 1'b0);
    end
  end

  always @(negedge clk) begin
    chk("model_dataOut", dataOut, m_dout);
    chk("model_carry", carry, m_carry);
    chk("model_eq", eq, (opnd(asel, 1'b0) == opnd(bsel, 1'b1)));
  end

  task automatic setin(input logic [1:0] w, input logic ws, input logic [1:0] a,
                       input logic [1:0] b, input logic ds, input logic [1:0] op,
                       input logic [2:0] rr, input logic [W-1:0] d);
    wen = w; wsel = ws; asel = a; bsel = b; datasel = ds; alusel = op; resreg = rr; din = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ld(input int i, input logic [W-1:0] v);
    setin(2'(i + 1), 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 3'b000, v);
    tick();
  endtask

  task automatic rd(input string name, input int i, input logic [W-1:0] exp);
    setin(2'b00, 1'b1, 2'(i), 2'b00, 1'b0, 2'b00, 3'b000, 8'h00);
    tick();
    chk(name, dataOut, exp);
  endtask

  initial begin
    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    chk("reset_dataOut", dataOut, 8'h00);
    chk("reset_carry", carry, 1'b0);

    // 1: load and read back
    ld(0, 8'h2A);
    rd("load_r0", 0, 8'h2A);

    // 2: add with and without carry
    ld(0, 8'hF0); ld(1, 8'h20);
    setin(2'b11, 1'b0, 2'b00, 2'b01, 1'b0, 2'b00, 3'b000, 8'h00); tick();
    chk("add_carry1", carry, 1'b1);
    rd("add_r2_10", 2, 8'h10);
    ld(1, 8'h0F);
    setin(2'b11, 1'b0, 2'b00, 2'b01, 1'b0, 2'b00, 3'b000, 8'h00); tick();
    chk("add_carry0", carry, 1'b0);
    rd("add_r2_ff", 2, 8'hFF);

    // 3: subtract, borrow and eq
    ld(0, 8'h05); ld(1, 8'h05);
    setin(2'b00, 1'b0, 2'b00, 2'b01, 1'b0, 2'b00, 3'b000, 8'h00); #1;
    chk("eq_same", eq, 1'b1);
    setin(2'b01, 1'b0, 2'b00, 2'b01, 1'b0, 2'b01, 3'b000, 8'h00); #1;
    chk("eq_with_wen", eq, 1'b1);
    tick();
    chk("sub_noborrow", carry, 1'b0);
    setin(2'b00, 1'b0, 2'b00, 2'b11, 1'b0, 2'b00, 3'b000, 8'h00); #1;
    chk("eq_const1", eq, 1'b0);
    setin(2'b10, 1'b0, 2'b00, 2'b11, 1'b0, 2'b01, 3'b000, 8'h00); tick();
    chk("sub_borrow", carry, 1'b1);
    rd("sub_r0_00", 0, 8'h00);
    rd("sub_r1_ff", 1, 8'hFF);

    // 4: clear priority
    ld(1, 8'h33);
    setin(2'b10, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 3'b010, 8'h77); tick();
    chk("clr_carry_hold", carry, 1'b1);
    rd("clr_r1", 1, 8'h00);
    setin(2'b10, 1'b0, 2'b00, 2'b11, 1'b0, 2'b00, 3'b010, 8'h00); tick();
    chk("clr_alu_carry_hold", carry, 1'b1);
    ld(0, 8'h11); ld(1, 8'h55); ld(2, 8'h22);
    setin(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 3'b101, 8'h00); tick();
    rd("clr_r0", 0, 8'h00);
    rd("clr_r1_kept", 1, 8'h55);
    rd("clr_r2", 2, 8'h00);

    // 5: read-before-write
    ld(2, 8'h09);
    setin(2'b11, 1'b1, 2'b10, 2'b00, 1'b1, 2'b00, 3'b000, 8'h44); tick();
    chk("rbw_dataOut", dataOut, 8'h09);
    rd("rbw_r2", 2, 8'h44);

    // 6: asynchronous reset between edges with a write pending
    ld(0, 8'hAA); ld(1, 8'hBB);
    rd("pre_rst_r1", 1, 8'hBB);
    chk("pre_rst_carry", carry, 1'b1);
    setin(2'b01, 1'b0, 2'b00, 2'b01, 1'b1, 2'b00, 3'b000, 8'h5A);
    #1 rst = 1'b1;
    #1;
    chk("arst_dataOut", dataOut, 8'h00);
    chk("arst_carry", carry, 1'b0);
    chk("arst_eq", eq, 1'b1);
    tick();
    rst = 1'b0;
    rd("arst_r0", 0, 8'h00);
    rd("arst_r1", 1, 8'h00);
    rd("arst_r2", 2, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
